// File: rtl/ws2812b_frame_serializer.sv
// ws2812b_frame_serializer
// Takes 24-bit GRB words over a valid/ready stream, shifts them out MSB-first
// one bit per BIT_PERIOD_CLK_COUNTS cycles (trigger + bit_to_code for the NRZ
// encoder), then holds the line low for LATCH_CLK_COUNTS cycles and pulses
// frame_done.
// Optional build macro: WS2812B_UNDERRUN_PAD_EN -- a missing pixel mid-frame
// is replaced by an all-zero pixel instead of cutting the frame short.
module ws2812b_frame_serializer #(
  parameter int LED_COUNT             = 8,
  parameter int BIT_PERIOD_CLK_COUNTS = 62,
  parameter int LATCH_CLK_COUNTS      = 2500,
  parameter int PIXEL_WIDTH           = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic                   trigger,
  output logic                   bit_to_code,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun
);

  localparam int PER_W = (BIT_PERIOD_CLK_COUNTS > 1) ? $clog2(BIT_PERIOD_CLK_COUNTS) : 1;
  localparam int BIT_W = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
  localparam int LAT_W = (LATCH_CLK_COUNTS > 1) ? $clog2(LATCH_CLK_COUNTS) : 1;
  localparam int CNT_W = $clog2(LED_COUNT + 1);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_PERIOD_CLK_COUNTS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIXEL_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CLK_COUNTS - 1);
  localparam logic [CNT_W-1:0] LEDS     = CNT_W'(LED_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, SHIFT, LATCH} state_t;

  state_t                 state;
  logic [PIXEL_WIDTH-1:0] hold_word;
  logic [PIXEL_WIDTH-1:0] shift_word;
  logic [PIXEL_WIDTH-1:0] next_word;
  logic                   hold_full;
  logic                   aborted;
  logic [CNT_W-1:0]       accepted;
  logic [CNT_W-1:0]       sent;
  logic [PER_W-1:0]       period_cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [LAT_W-1:0]       latch_cnt;

  logic take;
  logic load;
  logic load_any;
  logic pad_load;
  logic bit_end;
  logic pixel_end;
  logic frame_full;
  logic starve;
  logic latch_end;
  logic discard;

  assign pixel_ready = !hold_full && (accepted < LEDS);
  assign take        = pixel_valid && pixel_ready;
  assign bit_end     = (period_cnt == PER_LAST);
  assign pixel_end   = (state == SHIFT) && bit_end && (bit_idx == BIT_LAST);
  assign frame_full  = (sent == LEDS);
  assign starve      = pixel_end && !frame_full && !hold_full;
  assign latch_end   = (state == LATCH) && (latch_cnt == LAT_LAST);
  // A frame that hit an underrun drops whatever word is left over at its end.
  assign discard     = latch_end && aborted;

`ifdef WS2812B_UNDERRUN_PAD_EN
  assign pad_load = starve;
`else
  assign pad_load = 1'b0;
`endif

  assign load_any  = load || pad_load;
  assign next_word = pad_load ? '0 : hold_word;

  // Decide when the holding register is moved into the shift register
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:       load = start && hold_full;
      WAIT_FIRST: load = hold_full;
      SHIFT:      load = pixel_end && !frame_full && hold_full;
      default:    load = 1'b0;
    endcase
  end

  // One-word holding register and per-frame acceptance count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_word <= '0;
      hold_full <= 1'b0;
      accepted  <= '0;
    end else begin
      if (take) hold_word <= pixel_data;
      if (discard)       hold_full <= 1'b0;
      else if (take)     hold_full <= 1'b1;
      else if (load)     hold_full <= 1'b0;
      // The count restarts in the frame_done cycle so pixel_ready returns
      // one cycle later; a word taken in that cycle already counts.
      if (frame_done)    accepted <= take ? CNT_W'(1) : '0;
      else if (take)     accepted <= accepted + CNT_W'(1);
    end
  end

  // Frame sequencer: bit timing, shifting, latch gap and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_word  <= '0;
      period_cnt  <= '0;
      bit_idx     <= '0;
      latch_cnt   <= '0;
      sent        <= '0;
      aborted     <= 1'b0;
      trigger     <= 1'b0;
      bit_to_code <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      trigger    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          bit_to_code <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            state <= WAIT_FIRST;  // overridden below when a word is ready
          end
        end
        WAIT_FIRST: begin
          bit_to_code <= 1'b0;
        end
        SHIFT: begin
          if (!bit_end) begin
            period_cnt <= period_cnt + PER_W'(1);
          end else if (bit_idx != BIT_LAST) begin
            period_cnt  <= '0;
            bit_idx     <= bit_idx + BIT_W'(1);
            trigger     <= 1'b1;
            bit_to_code <= shift_word[PIXEL_WIDTH-1];
            shift_word  <= shift_word << 1;
          end else if (frame_full) begin
            state       <= LATCH;
            bit_to_code <= 1'b0;
            latch_cnt   <= '0;
          end else if (starve) begin
            underrun <= 1'b1;
            aborted  <= 1'b1;
`ifdef WS2812B_UNDERRUN_PAD_EN
            // zero pixel is loaded by the common load path below
`else
            state       <= LATCH;
            bit_to_code <= 1'b0;
            latch_cnt   <= '0;
`endif
          end
        end
        LATCH: begin
          bit_to_code <= 1'b0;
          if (latch_cnt == LAT_LAST) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            latch_cnt  <= '0;
            sent       <= '0;
            aborted    <= 1'b0;
          end else begin
            latch_cnt <= latch_cnt + LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Common load path: first bit of the new word goes out next cycle
      if (load_any) begin
        state       <= SHIFT;
        shift_word  <= next_word << 1;
        bit_to_code <= next_word[PIXEL_WIDTH-1];
        trigger     <= 1'b1;
        period_cnt  <= '0;
        bit_idx     <= '0;
        sent        <= sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_serializer.sv
// Testbench for ws2812b_frame_serializer (default build, padding macro off).
// A monitor logs every trigger/bit, frame_done and underrun with its cycle
// number; each frame's log is compared against timing and bit order derived
// from the pixel list that was fed in.
module tb_ws2812b_frame_serializer;
  localparam int N = 3;   // LED_COUNT
  localparam int P = 10;  // BIT_PERIOD_CLK_COUNTS
  localparam int L = 50;  // LATCH_CLK_COUNTS
  localparam int W = 24;  // PIXEL_WIDTH

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] pixel_data = '0;
  logic         pixel_valid = 1'b0;
  logic         pixel_ready, trigger, bit_to_code, busy, frame_done, underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int           trig_t[$];
  bit           trig_b[$];
  int           fd_t[$];
  int           ur_t[$];
  logic [W-1:0] feed_q[$];
  logic [W-1:0] frame_px[$];
  int           take_cnt = 0;
  int           last_take_cyc = 0;

  ws2812b_frame_serializer #(
    .LED_COUNT(N), .BIT_PERIOD_CLK_COUNTS(P),
    .LATCH_CLK_COUNTS(L), .PIXEL_WIDTH(W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .trigger(trigger), .bit_to_code(bit_to_code), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (trigger) begin
        trig_t.push_back(cyc);
        trig_b.push_back(bit_to_code);
      end
      if (frame_done) fd_t.push_back(cyc);
      if (underrun)   ur_t.push_back(cyc);
    end
  end

  // source: offers feed_q words one at a time on the valid/ready stream
  initial begin : feeder
    bit take;
    forever begin
      @(negedge clk);
      if (feed_q.size() > 0) begin
        pixel_valid = 1'b1;
        pixel_data  = feed_q[0];
      end else begin
        pixel_valid = 1'b0;
        pixel_data  = '0;
      end
      #4;
      take = reset && pixel_valid && pixel_ready;
      if (take) last_take_cyc = cyc;
      @(posedge clk);
      if (take && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        take_cnt++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start(output int t);
    @(negedge clk);
    t = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_px(input logic [W-1:0] v);
    feed_q.push_back(v);
    frame_px.push_back(v);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push_px(W'($urandom()));
  endtask

  task automatic wait_take(input string tag, input int target);
    int n = 0;
    while (take_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, (take_cnt >= target), 1);
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    while (fd_t.size() < 1 && n < N * W * P + L + 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, (fd_t.size() >= 1), 1);
  endtask

  task automatic clear_logs();
    trig_t.delete();
    trig_b.delete();
    fd_t.delete();
    ur_t.delete();
  endtask

  // Compare one frame's log with the expected schedule: npx pixels, bit k
  // triggered at t1 + k*P carrying bit (W-1 - k%W) of pixel k/W.
  task automatic check_frame(input string name, input int t1, input int npx, input bit exp_ur);
    int nt, bad_t, bad_b, first_bad, lim;
    bit eb;
    wait_cycles(2 * P);
    nt = npx * W;
    bad_t = 0;
    bad_b = 0;
    first_bad = -1;
    check($sformatf("%s trig_count", name), trig_t.size(), nt);
    lim = (trig_t.size() < nt) ? trig_t.size() : nt;
    for (int k = 0; k < lim; k++) begin
      eb = frame_px[k / W][W - 1 - (k % W)];
      if (trig_t[k] != t1 + k * P) begin
        bad_t++;
        if (first_bad < 0) first_bad = k;
      end
      if (trig_b[k] !== eb) begin
        bad_b++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (first_bad >= 0)
      $display("%s first bad trigger index %0d", name, first_bad);
    check($sformatf("%s trig_time_errs", name), bad_t, 0);
    check($sformatf("%s bit_errs", name), bad_b, 0);
    check($sformatf("%s underrun_count", name), ur_t.size(), exp_ur ? 1 : 0);
    if (exp_ur && ur_t.size() > 0)
      check($sformatf("%s underrun_cycle", name), ur_t[0], t1 + nt * P);
    check($sformatf("%s frame_done_count", name), fd_t.size(), 1);
    if (fd_t.size() > 0)
      check($sformatf("%s frame_done_cycle", name), fd_t[0], t1 + nt * P + L);
    check($sformatf("%s busy_idle", name), busy, 0);
    $display("frame %s: t1=%0d pixels=%0d triggers=%0d underruns=%0d frame_done=%0d",
             name, t1, npx, trig_t.size(), ur_t.size(), fd_t.size());
    for (int i = 0; i < npx && frame_px.size() > 0; i++) void'(frame_px.pop_front());
    clear_logs();
  endtask

  initial begin : stimulus
    int t, t2, c, base, m, d, n;

    // ---- reset state
    wait_cycles(2);
    check("rst trigger", trigger, 0);
    check("rst bit_to_code", bit_to_code, 0);
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst underrun", underrun, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst pixel_ready", pixel_ready, 1);

    // ---- frame A: known pixels, prefetched, stray starts in SHIFT and LATCH
    base = take_cnt;
    push_px(24'hFF0000);
    push_px(24'h00000F);
    push_random(1);
    wait_take("A prefetch", base + 1);
    pulse_start(t);
    wait_cycles(3);
    check("A busy", busy, 1);
    wait_until_cyc(t + 1 + 5 * P);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until_cyc(t + 1 + N * W * P + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fd("A frame_done seen");
    check_frame("A", t + 1, N, 1'b0);

    // ---- reset in the middle of SHIFT, at trigger #5
    base = take_cnt;
    push_random(N);
    wait_take("R prefetch", base + 1);
    pulse_start(t);
    n = 0;
    while (trig_t.size() < 5 && n < 10 * P) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("R trigger5 seen", trigger, 1);
    reset = 1'b0;
    feed_q.delete();
    frame_px.delete();
    #1;
    check("R trigger", trigger, 0);
    check("R bit_to_code", bit_to_code, 0);
    check("R busy", busy, 0);
    clear_logs();
    wait_cycles(2);
    reset = 1'b1;
    @(negedge clk);
    check("R pixel_ready", pixel_ready, 1);
    $display("reset mid-frame: released at cycle %0d", cyc);

    // ---- start with nothing held, word arrives later
    pulse_start(t);
    wait_cycles(3);
    check("WF busy", busy, 1);
    check("WF trigger", trigger, 0);
    d = $urandom_range(20, 100);
    wait_cycles(d);
    base = take_cnt;
    push_random(N);
    wait_take("WF first word", base + 1);
    c = last_take_cyc;
    wait_fd("WF frame_done seen");
    check_frame("WF", c + 2, N, 1'b0);

    // ---- underrun: fewer pixels than LED_COUNT
    m = $urandom_range(1, N - 1);
    base = take_cnt;
    push_random(m);
    wait_take("U prefetch", base + 1);
    pulse_start(t);
    wait_fd("U frame_done seen");
    check_frame("U", t + 1, m, 1'b1);

    // ---- continuous valid: acceptance stops at LED_COUNT per frame
    base = take_cnt;
    push_random(2 * N);
    wait_take("C prefetch", base + 1);
    pulse_start(t);
    wait_fd("C1 frame_done seen");
    check("C ready at frame_done", pixel_ready, 0);
    check("C takes in frame", take_cnt - base, N);
    @(negedge clk);
    check("C ready after frame_done", pixel_ready, 1);
    check_frame("C1", t + 1, N, 1'b0);
    pulse_start(t2);
    wait_fd("C2 frame_done seen");
    check_frame("C2", t2 + 1, N, 1'b0);

    // ---- random frames
    for (int f = 0; f < 2; f++) begin
      base = take_cnt;
      push_random(N);
      wait_take("RND prefetch", base + 1);
      wait_cycles($urandom_range(0, 5));
      pulse_start(t);
      wait_fd("RND frame_done seen");
      check_frame($sformatf("RND%0d", f), t + 1, N, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
